scarv_soc_bram_bus_adapter: RTL and testbench
=============================================

# scarv_soc_bram_bus_adapter

Bridges the SoC request/response memory bus onto a single-port, one-cycle-latency BRAM macro port (ena/wea/addra/dina/douta). Sits directly upstream of the single-port BRAM: converts bus requests into BRAM port strobes, captures read data, and holds each response until the bus master accepts it. Supports one outstanding transaction with back-to-back issue, giving one access per cycle when the master acks immediately.

## Interface
- DEPTH, 1024: BRAM size in bytes; power of two, 8..16384; LW = clog2(DEPTH).
- BASE, 32'h0000_0000: bus address of BRAM byte 0; DEPTH-aligned.

- g_clk  in  1  system clock; all logic on rising edge.
- g_resetn  in  1  synchronous, active-low reset.
- mem_req  in  1  request valid.
- mem_gnt  out  1  request accepted this cycle; combinational.
- mem_wen  in  1  1 = write, 0 = read.
- mem_strb  in  4  write byte strobes.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_recv  out  1  response valid.
- mem_ack  in  1  master accepts response.
- mem_error  out  1  response is an error.
- mem_rdata  out  32  read data.
- bram_rsta  out  1  BRAM output reset; equals ~g_resetn.
- bram_ena  out  1  BRAM enable.
- bram_wea  out  4  BRAM byte write enables.
- bram_addra  out  14  BRAM byte address, word aligned.
- bram_dina  out  32  BRAM write data.
- bram_douta  in  32  BRAM read data, valid one cycle after ena.

## Operation
- States: IDLE (nothing outstanding), RSP (response from bram_douta this cycle), HOLD (response from internal register).
- mem_gnt = mem_req & (IDLE | ((RSP | HOLD) & mem_ack)).
- On grant: bram_ena = 1 if in range; bram_wea = mem_wen ? mem_strb : 4'b0; bram_addra = zero-extended {off[LW-1:2],2'b00}, off = mem_addr - BASE; bram_dina = mem_wdata. Not granted: bram_ena = 0, bram_wea = 0.
- Grant -> RSP next cycle. RSP: mem_recv = 1; mem_rdata = bram_douta for reads, 0 for writes.
- RSP & !mem_ack: capture mem_rdata/mem_error into hold register -> HOLD. HOLD outputs register unchanged until acked.
- (RSP | HOLD) & mem_ack: new grant -> RSP; else -> IDLE.
- Write with mem_strb = 0: granted, no bytes change, normal response.
- Reads never change memory; bram_ena is never asserted unless granted.

## Timing
- Reset: state IDLE, mem_recv 0, mem_error 0, mem_rdata 0, hold register 0; bram_ena/bram_wea 0 while g_resetn low.
- Latency: grant at cycle N -> mem_recv at N+1.
- Throughput: 1 transaction/cycle with mem_ack held high.
- Master holds the request stable until mem_gnt; mem_recv stays high and mem_rdata/mem_error stable until mem_ack.
- Reset during RSP/HOLD: response dropped; mem_recv 0 in the cycle after reset is sampled; no BRAM write issued in that cycle.
- mem_ack while mem_recv is 0: ignored.

## Configuration
- SCARV_SOC_BRAM_ERR_EN defined: an access with off >= DEPTH is granted with bram_ena = 0 and answered at N+1 with mem_error = 1, mem_rdata = 0; memory is unchanged.
- Undefined: no range check; off wraps modulo DEPTH; mem_error tied 0.

## Test plan
- Reset: hold g_resetn = 0 for 3 cycles with mem_req = 1 -> mem_gnt 0, mem_recv 0, mem_rdata 0, bram_ena 0, bram_rsta 1.
- Write 0xDEADBEEF to BASE+0x10 (strb 4'hF), then read it -> bram_wea 4'hF, bram_addra 0x10, then mem_rdata 0xDEADBEEF at N+1.
- Partial write: strb 4'b0100, wdata 0x00AA0000 at 0x10, then read -> 0xDEAABEEF.
- Back-to-back reads of 0x0, 0x4, 0x8 with mem_ack = 1 -> grants on 3 consecutive cycles, responses on 3 consecutive cycles in order.
- Backpressure: read 0x10, mem_ack = 0 for 4 cycles while the BRAM receives no other accesses -> mem_recv high and mem_rdata 0xDEAABEEF stable; a pending second request is not granted until the ack cycle.
- With SCARV_SOC_BRAM_ERR_EN, read BASE+DEPTH -> bram_ena 0, mem_error 1, mem_rdata 0. Without the macro, the same read returns the word at off 0.

Source files
------------

// File: rtl/scarv_soc_bram_bus_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : scarv_soc_bram_bus_adapter                                 |
// | Description : SoC req/resp memory bus to single-port 1-cycle BRAM port.  |
// |               Optional range check enabled by SCARV_SOC_BRAM_ERR_EN.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module scarv_soc_bram_bus_adapter #(
    parameter int          DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        mem_req,
    output logic        mem_gnt,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata,
    output logic        bram_rsta,
    output logic        bram_ena,
    output logic [3:0]  bram_wea,
    output logic [13:0] bram_addra,
    output logic [31:0] bram_dina,
    input  logic [31:0] bram_douta
);

    localparam logic [13:0] ADDR_MASK = 14'(DEPTH - 1) & 14'h3ffc;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RSP  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        rsp_wen_q, rsp_wen_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] hold_rdata_q, hold_rdata_d;
    logic        hold_err_q, hold_err_d;

    logic [31:0] off;
    logic        in_range;
    logic        gnt;
    logic [31:0] rsp_rdata;
    logic        unused_off_bits;

    assign off             = mem_addr - BASE;
    assign unused_off_bits = ^{off[31:14], off[1:0]};

`ifdef SCARV_SOC_BRAM_ERR_EN
    assign in_range = (off < 32'(DEPTH));
`else
    assign in_range = 1'b1;
`endif

    // Writes and out-of-range accesses answer with zero data.
    assign rsp_rdata = (rsp_wen_q || rsp_err_q) ? 32'h0 : bram_douta;

    always_comb begin
        state_d      = state_q;
        rsp_wen_d    = rsp_wen_q;
        rsp_err_d    = rsp_err_q;
        hold_rdata_d = hold_rdata_q;
        hold_err_d   = hold_err_q;
        gnt          = 1'b0;
        mem_recv     = 1'b0;
        mem_rdata    = 32'h0;
        mem_error    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt = mem_req && g_resetn;
            end
            ST_RSP: begin
                mem_recv  = 1'b1;
                mem_rdata = rsp_rdata;
                mem_error = rsp_err_q;
                gnt       = mem_req && mem_ack && g_resetn;
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_rdata_d = rsp_rdata;
                    hold_err_d   = rsp_err_q;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                mem_recv  = 1'b1;
                mem_rdata = hold_rdata_q;
                mem_error = hold_err_q;
                gnt       = mem_req && mem_ack && g_resetn;
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (gnt) begin
            state_d   = ST_RSP;
            rsp_wen_d = mem_wen;
            rsp_err_d = !in_range;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q      <= ST_IDLE;
            rsp_wen_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            hold_rdata_q <= 32'h0;
            hold_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_wen_q    <= rsp_wen_d;
            rsp_err_q    <= rsp_err_d;
            hold_rdata_q <= hold_rdata_d;
            hold_err_q   <= hold_err_d;
        end
    end

    assign mem_gnt    = gnt;
    assign bram_rsta  = !g_resetn;
    assign bram_ena   = gnt && in_range;
    assign bram_wea   = (gnt && in_range && mem_wen) ? mem_strb : 4'b0000;
    assign bram_addra = off[13:0] & ADDR_MASK;
    assign bram_dina  = mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_scarv_soc_bram_bus_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_scarv_soc_bram_bus_adapter                              |
// | Description : Directed + random bench for the BRAM bus adapter.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_scarv_soc_bram_bus_adapter;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          WORDS = DEPTH / 4;

    logic        g_clk;
    logic        g_resetn;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;
    logic        bram_rsta;
    logic        bram_ena;
    logic [3:0]  bram_wea;
    logic [13:0] bram_addra;
    logic [31:0] bram_dina;
    logic [31:0] bram_douta = 32'h0;

    logic [31:0] bram_mem [WORDS] = '{default: 32'h0};
    logic [31:0] ref_mem  [WORDS];

    int checks   = 0;
    int failures = 0;

    scarv_soc_bram_bus_adapter #(
        .DEPTH (DEPTH),
        .BASE  (BASE)
    ) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_recv   (mem_recv),
        .mem_ack    (mem_ack),
        .mem_error  (mem_error),
        .mem_rdata  (mem_rdata),
        .bram_rsta  (bram_rsta),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_douta (bram_douta)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    // Single-port BRAM with one-cycle read latency, read-first.
    always @(posedge g_clk) begin
        if (bram_ena) begin
            bram_douta <= bram_mem[int'(bram_addra >> 2)];
            for (int b = 0; b < 4; b++) begin
                if (bram_wea[b]) begin
                    bram_mem[int'(bram_addra >> 2)][8*b +: 8] <= bram_dina[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
`ifdef SCARV_SOC_BRAM_ERR_EN
        return off < 32'(DEPTH);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int model_word(input logic [31:0] addr);
        return int'(((addr - BASE) % 32'(DEPTH)) / 4);
    endfunction

    // One complete transaction from IDLE: grant, response held for 'stall' cycles, ack.
    task automatic do_txn(input logic wen, input logic [3:0] strb, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall);
        logic        in_rng;
        int          widx;
        logic [31:0] exp_rd;
        in_rng = model_in_range(addr);
        widx   = model_word(addr);
        exp_rd = (wen || !in_rng) ? 32'h0 : ref_mem[widx];

        @(negedge g_clk);
        mem_req   = 1'b1;
        mem_wen   = wen;
        mem_strb  = strb;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_ack   = 1'b0;
        #1;
        check("txn_gnt", 32'(mem_gnt), 32'd1);
        check("txn_ena", 32'(bram_ena), 32'(in_rng));
        if (in_rng) begin
            check("txn_wea", 32'(bram_wea), 32'(wen ? strb : 4'b0000));
            check("txn_addra", 32'(bram_addra), 32'(widx * 4));
            if (wen) check("txn_dina", bram_dina, wdata);
        end
        if (wen && in_rng) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) ref_mem[widx][8*b +: 8] = wdata[8*b +: 8];
            end
        end

        for (int i = 0; i <= stall; i++) begin
            @(negedge g_clk);
            mem_req = 1'b0;
            #1;
            check("rsp_recv", 32'(mem_recv), 32'd1);
            check("rsp_rdata", mem_rdata, exp_rd);
            check("rsp_error", 32'(mem_error), 32'(!in_rng));
            if (i > 0) check("rsp_no_ena", 32'(bram_ena), 32'd0);
            mem_ack = (i == stall);
        end

        @(negedge g_clk);
        mem_ack = 1'b0;
        #1;
        check("rsp_done", 32'(mem_recv), 32'd0);
    endtask

    initial begin
        logic [31:0] rnd;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;

        g_resetn  = 1'b0;
        mem_req   = 1'b1;
        mem_wen   = 1'b1;
        mem_strb  = 4'hF;
        mem_addr  = BASE;
        mem_wdata = 32'h1234_5678;
        mem_ack   = 1'b0;

        // Reset held with an active request.
        repeat (3) begin
            @(negedge g_clk);
            #1;
            check("rst_gnt", 32'(mem_gnt), 32'd0);
            check("rst_recv", 32'(mem_recv), 32'd0);
            check("rst_rdata", mem_rdata, 32'h0);
            check("rst_ena", 32'(bram_ena), 32'd0);
            check("rst_wea", 32'(bram_wea), 32'd0);
            check("rst_rsta", 32'(bram_rsta), 32'd1);
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        mem_req  = 1'b0;
        #1;
        check("rst_rsta_rel", 32'(bram_rsta), 32'd0);

        // Full write then read back.
        do_txn(1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 4'h0, BASE + 32'h10, 32'h0, 0);

        // Partial write of byte 2.
        do_txn(1'b1, 4'b0100, BASE + 32'h10, 32'h00AA_0000, 0);
        do_txn(1'b0, 4'h0, BASE + 32'h10, 32'h0, 0);
        check("partial_model", ref_mem[4], 32'hDEAA_BEEF);

        // Zero-strobe write leaves memory alone.
        do_txn(1'b1, 4'h0, BASE + 32'h10, 32'hFFFF_FFFF, 1);
        do_txn(1'b0, 4'h0, BASE + 32'h13, 32'h0, 0);

        // Seed three words, then read them back-to-back.
        for (int i = 0; i < 3; i++) begin
            rnd = $urandom;
            do_txn(1'b1, 4'hF, BASE + 32'(4 * i), rnd, 0);
        end
        @(negedge g_clk);
        mem_req = 1'b1;
        mem_wen = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) mem_addr = BASE + 32'(4 * i);
            else       mem_req  = 1'b0;
            #1;
            check("b2b_gnt", 32'(mem_gnt), 32'(i < 3));
            if (i < 3) check("b2b_addra", 32'(bram_addra), 32'(4 * i));
            check("b2b_recv", 32'(mem_recv), 32'(i > 0));
            if (i > 0) check("b2b_rdata", mem_rdata, ref_mem[i - 1]);
            @(negedge g_clk);
        end
        mem_ack = 1'b0;
        #1;
        check("b2b_done", 32'(mem_recv), 32'd0);

        // Backpressure with a second request waiting.
        @(negedge g_clk);
        mem_req  = 1'b1;
        mem_wen  = 1'b0;
        mem_addr = BASE + 32'h10;
        mem_ack  = 1'b0;
        #1;
        check("bp_gnt0", 32'(mem_gnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge g_clk);
            mem_addr = BASE;
            #1;
            check("bp_stall_gnt", 32'(mem_gnt), 32'd0);
            check("bp_stall_ena", 32'(bram_ena), 32'd0);
            check("bp_stall_recv", 32'(mem_recv), 32'd1);
            check("bp_stall_rdata", mem_rdata, 32'hDEAA_BEEF);
        end
        @(negedge g_clk);
        mem_ack = 1'b1;
        #1;
        check("bp_ack_gnt", 32'(mem_gnt), 32'd1);
        check("bp_ack_ena", 32'(bram_ena), 32'd1);
        check("bp_ack_addra", 32'(bram_addra), 32'h0);
        check("bp_ack_rdata", mem_rdata, 32'hDEAA_BEEF);
        @(negedge g_clk);
        mem_req = 1'b0;
        #1;
        check("bp_second_recv", 32'(mem_recv), 32'd1);
        check("bp_second_rdata", mem_rdata, ref_mem[0]);
        @(negedge g_clk);
        mem_ack = 1'b0;
        #1;
        check("bp_done", 32'(mem_recv), 32'd0);

        // Reset while a response is pending: response dropped, no BRAM write.
        @(negedge g_clk);
        mem_req  = 1'b1;
        mem_wen  = 1'b0;
        mem_addr = BASE + 32'h10;
        #1;
        check("rr_gnt", 32'(mem_gnt), 32'd1);
        @(negedge g_clk);
        g_resetn  = 1'b0;
        mem_wen   = 1'b1;
        mem_strb  = 4'hF;
        mem_wdata = 32'h5555_AAAA;
        #1;
        check("rr_gnt_rst", 32'(mem_gnt), 32'd0);
        check("rr_ena_rst", 32'(bram_ena), 32'd0);
        check("rr_wea_rst", 32'(bram_wea), 32'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        mem_req  = 1'b0;
        #1;
        check("rr_recv", 32'(mem_recv), 32'd0);
        do_txn(1'b0, 4'h0, BASE + 32'h10, 32'h0, 0);

        // Access just past the end: error response or wrap to offset 0.
        do_txn(1'b0, 4'h0, BASE + 32'(DEPTH), 32'h0, 1);
        do_txn(1'b1, 4'hF, BASE + 32'(DEPTH) + 32'h4, 32'hCAFE_F00D, 0);
        do_txn(1'b0, 4'h0, BASE + 32'h4, 32'h0, 0);

        // Random traffic over in-range and out-of-range addresses.
        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   BASE + 32'($urandom_range(0, 2 * DEPTH - 1)), $urandom,
                   int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
